// File: rtl/spdif_frame_tx.sv
// spdif_frame_tx
// S/PDIF (IEC 60958) biphase-mark transmitter. It pulls one 20-bit sample per
// subframe from a standard (non-FWFT) FIFO and builds each 32-slot subframe on
// the fly: preamble, zero aux, audio LSB first, V, U, C and even parity P.
// Left and right subframes alternate. Channel status runs on a 192-frame block.
// One line cell is produced per clock, so each frame takes 128 clocks.
//
// Ports
//   clk          6.144 MHz cell clock
//   rst_n        asynchronous active-low reset
//   en           transmit enable; low holds the block idle
//   din          FIFO read data, valid the cycle after rd_en
//   empty        FIFO empty flag
//   rd_en        one-cycle FIFO read strobe (registered)
//   dout         biphase-mark line level (registered)
//   frame_start  pulse aligned with the first cell of every frame on dout
//   underrun     sticky missed-sample flag, cleared only by rst_n
module spdif_frame_tx #(
  parameter logic [31:0] CHAN_STATUS = 32'h0000_0004,
  parameter int          SAMPLE_W    = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] din,
  input  logic                empty,
  output logic                rd_en,
  output logic                dout,
  output logic                frame_start,
  output logic                underrun
);

  // Preamble cell patterns, first cell in the MSB, for a line level of 0
  // at the end of the previous subframe.
  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  // PRIME is the single cycle between enable and cell 0; it acts as the
  // fetch point for the very first left subframe.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t              state_r;
  logic [6:0]          cell_cnt_r;
  logic [7:0]          frame_cnt_r;
  logic [SAMPLE_W-1:0] sample_r;
  logic                v_r;
  logic                fetch_ok_r;
  logic                par_r;
  logic                pol_r;
  logic                dout_r;
  logic                rd_en_r;
  logic                frame_start_r;
  logic                underrun_r;

  logic [4:0]          slot_s;
  logic                half_s;
  logic                cs_bit_s;
  logic [7:0]          pre_pat_s;
  logic [2:0]          pre_idx_s;
  logic                pre_bit_s;
  logic                pol_s;
  logic                slot_bit_s;
  logic                level_s;

  // Serial even-parity step; 'clear' restarts the accumulation at slot 4.
  function automatic logic par_step(input logic acc, input logic bit_in,
                                    input logic clear);
    logic res;
    if (clear) begin
      res = bit_in;
    end else begin
      res = acc ^ bit_in;
    end
    return res;
  endfunction

  // Decode the cell counter into the line level for the current cell.
  always_comb begin
    slot_s    = cell_cnt_r[5:1];
    half_s    = cell_cnt_r[0];
    pre_idx_s = 3'd7 - cell_cnt_r[2:0];

    if (frame_cnt_r < 8'd32) begin
      cs_bit_s = CHAN_STATUS[frame_cnt_r[4:0]];
    end else begin
      cs_bit_s = 1'b0;
    end

    if (cell_cnt_r[6]) begin
      pre_pat_s = PRE_W;
    end else if (frame_cnt_r == 8'd0) begin
      pre_pat_s = PRE_B;
    end else begin
      pre_pat_s = PRE_M;
    end
    pre_bit_s = pre_pat_s[pre_idx_s];

    // On the first preamble cell dout_r still holds the previous subframe's
    // final level; later preamble cells use the copy latched at that point.
    if (cell_cnt_r[5:0] == 6'd0) begin
      pol_s = dout_r;
    end else begin
      pol_s = pol_r;
    end

    if (slot_s < 5'd8) begin
      slot_bit_s = 1'b0;
    end else if (slot_s < 5'd28) begin
      slot_bit_s = sample_r[0];
    end else begin
      case (slot_s)
        5'd28:   slot_bit_s = v_r;
        5'd29:   slot_bit_s = 1'b0;
        5'd30:   slot_bit_s = cs_bit_s;
        5'd31:   slot_bit_s = par_r;
        default: slot_bit_s = 1'b0;
      endcase
    end

    if (slot_s < 5'd4) begin
      level_s = pre_bit_s ^ pol_s;
    end else if (!half_s) begin
      level_s = ~dout_r;
    end else begin
      level_s = dout_r ^ slot_bit_s;
    end
  end

  // Sequencer: counters, sample fetch/load, parity and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cell_cnt_r    <= 7'd0;
      frame_cnt_r   <= 8'd0;
      sample_r      <= {SAMPLE_W{1'b0}};
      v_r           <= 1'b0;
      fetch_ok_r    <= 1'b0;
      par_r         <= 1'b0;
      pol_r         <= 1'b0;
      dout_r        <= 1'b0;
      rd_en_r       <= 1'b0;
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      rd_en_r       <= 1'b0;
      frame_start_r <= 1'b0;
      if (!en) begin
        // Idle: everything back to frame 0 and any captured sample dropped.
        state_r     <= ST_IDLE;
        cell_cnt_r  <= 7'd0;
        frame_cnt_r <= 8'd0;
        sample_r    <= {SAMPLE_W{1'b0}};
        v_r         <= 1'b0;
        fetch_ok_r  <= 1'b0;
        par_r       <= 1'b0;
        pol_r       <= 1'b0;
        dout_r      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_PRIME;
          end
          ST_PRIME: begin
            rd_en_r    <= ~empty;
            fetch_ok_r <= ~empty;
            if (empty) begin
              underrun_r <= 1'b1;
            end else begin
              underrun_r <= underrun_r;
            end
            state_r <= ST_RUN;
          end
          ST_RUN: begin
            cell_cnt_r    <= cell_cnt_r + 7'd1;
            dout_r        <= level_s;
            frame_start_r <= (cell_cnt_r == 7'd0);

            if (cell_cnt_r == 7'd127) begin
              frame_cnt_r <= (frame_cnt_r == 8'd191) ? 8'd0 : frame_cnt_r + 8'd1;
            end else begin
              frame_cnt_r <= frame_cnt_r;
            end

            if (cell_cnt_r[5:0] == 6'd0) begin
              pol_r <= dout_r;
            end else begin
              pol_r <= pol_r;
            end

            // Last cell of a subframe is the fetch point for the next one.
            if (cell_cnt_r[5:0] == 6'd63) begin
              rd_en_r    <= ~empty;
              fetch_ok_r <= ~empty;
              if (empty) begin
                underrun_r <= 1'b1;
              end else begin
                underrun_r <= underrun_r;
              end
            end else begin
              fetch_ok_r <= fetch_ok_r;
            end

            // din is valid during cell 1 when a read was issued at cell 0.
            if (cell_cnt_r[5:0] == 6'd1) begin
              sample_r <= fetch_ok_r ? din : {SAMPLE_W{1'b0}};
              v_r      <= ~fetch_ok_r;
            end else if (half_s && (slot_s >= 5'd8) && (slot_s < 5'd28)) begin
              sample_r <= {1'b0, sample_r[SAMPLE_W-1:1]};
            end else begin
              sample_r <= sample_r;
            end

            if (half_s && (slot_s >= 5'd4) && (slot_s < 5'd31)) begin
              par_r <= par_step(par_r, slot_bit_s, slot_s == 5'd4);
            end else begin
              par_r <= par_r;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign rd_en       = rd_en_r;
  assign dout        = dout_r;
  assign frame_start = frame_start_r;
  assign underrun    = underrun_r;

endmodule

// File: tb/tb_spdif_frame_tx.sv
// Bench for spdif_frame_tx: a FIFO model feeds the DUT, and a subframe-level
// reference builds the expected 64-cell line pattern of every subframe from
// the IEC 60958 slot rules; dout, rd_en, frame_start and underrun are compared
// on every falling edge.
module tb_spdif_frame_tx;

  localparam logic [31:0] CS = 32'h0000_0004;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic [19:0] din   = 20'h00000;
  logic        empty = 1'b1;
  logic        rd_en;
  logic        dout;
  logic        frame_start;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  logic [19:0] fifo_q[$];
  bit          force_empty = 1'b0;
  int          rd_cnt = 0;

  int          m_n = 0;
  logic        m_level = 1'b0;
  logic        exp_q[$];
  logic        x_dout = 1'b0;
  logic        x_rd = 1'b0;
  logic        x_fs = 1'b0;
  logic        x_un = 1'b0;
  logic [63:0] m_cells;
  logic [19:0] m_smp;
  logic        m_v;
  int          m_s;

  logic [63:0] p_cells;
  logic [7:0]  p_head;
  int          base;

  spdif_frame_tx #(.CHAN_STATUS(CS), .SAMPLE_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .empty(empty),
    .rd_en(rd_en), .dout(dout), .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Expected 64 line cells of one subframe, cell i in bit i.
  task automatic make_sub(input int f, input bit right, input logic [19:0] smp,
                          input logic v, input logic lvl_in, output logic [63:0] cells);
    logic [31:0] b;
    logic [7:0]  pre;
    logic        lv;
    int          ones;
    b = 32'h0;
    for (int i = 0; i < 20; i++) b[8+i] = smp[i];
    b[28] = v;
    b[30] = (f < 32) ? CS[f] : 1'b0;
    ones = 0;
    for (int i = 4; i < 31; i++) ones += int'(b[i]);
    b[31] = ones[0];
    if (right) pre = 8'b11100100;
    else if (f == 0) pre = 8'b11101000;
    else pre = 8'b11100010;
    cells = 64'h0;
    for (int i = 0; i < 8; i++) cells[i] = pre[7-i] ^ lvl_in;
    lv = cells[7];
    for (int sl = 4; sl < 32; sl++) begin
      lv = ~lv;
      cells[2*sl] = lv;
      lv = lv ^ b[sl];
      cells[2*sl+1] = lv;
    end
  endtask

  task automatic refresh();
    empty = (fifo_q.size() == 0) || force_empty;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      refresh();
    end
  endtask

  // FIFO model: a read pops the head onto din one cycle later.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_cnt++;
      if (fifo_q.size() > 0) din <= fifo_q.pop_front();
    end
  end

  // Reference: m_n counts edges that saw en high; subframe s is decided at
  // edge 2+64s and its cells leave dout from edge 3+64s on.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; exp_q.delete(); m_level = 1'b0;
      x_dout = 1'b0; x_rd = 1'b0; x_fs = 1'b0; x_un = 1'b0;
    end else if (!en) begin
      m_n = 0; exp_q.delete(); m_level = 1'b0;
      x_dout = 1'b0; x_rd = 1'b0; x_fs = 1'b0;
    end else begin
      m_n++;
      x_rd = 1'b0;
      x_fs = 1'b0;
      if (m_n >= 2 && ((m_n - 2) % 64) == 0) begin
        m_s = (m_n - 2) / 64;
        if (!empty) begin
          m_smp = fifo_q[0]; m_v = 1'b0; x_rd = 1'b1;
        end else begin
          m_smp = 20'h00000; m_v = 1'b1; x_un = 1'b1;
        end
        make_sub((m_s / 2) % 192, bit'(m_s % 2), m_smp, m_v, m_level, m_cells);
        for (int i = 0; i < 64; i++) exp_q.push_back(m_cells[i]);
        m_level = m_cells[63];
      end
      if (m_n >= 3) begin
        x_dout = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
        x_fs = (((m_n - 3) % 128) == 0);
      end
    end
  end

  always @(negedge clk) begin
    check("dout", dout, x_dout);
    check("rd_en", rd_en, x_rd);
    check("frame_start", frame_start, x_fs);
    check("underrun", underrun, x_un);
  end

  initial begin
    // Hand-derived subframes pin the reference itself.
    make_sub(0, 1'b0, 20'h00001, 1'b0, 1'b0, p_cells);
    for (int i = 0; i < 8; i++) p_head[7-i] = p_cells[i];
    check("pin_B_pre", p_head, 8'b11101000);
    check("pin_L_slot8", {p_cells[16], p_cells[17]}, 2'b10);
    check("pin_L_P", {p_cells[62], p_cells[63]}, 2'b10);
    make_sub(0, 1'b1, 20'h80000, 1'b0, 1'b0, p_cells);
    for (int i = 0; i < 8; i++) p_head[7-i] = p_cells[i];
    check("pin_W_pre", p_head, 8'b11100100);
    check("pin_R_slot27", {p_cells[54], p_cells[55]}, 2'b01);
    check("pin_R_P", {p_cells[62], p_cells[63]}, 2'b10);
    make_sub(2, 1'b0, 20'h00000, 1'b0, 1'b0, p_cells);
    for (int i = 0; i < 8; i++) p_head[7-i] = p_cells[i];
    check("pin_M_pre", p_head, 8'b11100010);
    check("pin_C2_CP", {p_cells[60], p_cells[61], p_cells[62], p_cells[63]}, 4'b1010);

    // Reset then a long idle stretch.
    step(3);
    rst_n = 1'b1;
    step(500);

    // Single frame: one left and one right sample.
    fifo_q.push_back(20'h00001);
    fifo_q.push_back(20'h80000);
    refresh();
    en = 1'b1;
    base = rd_cnt;
    step(100);
    check("single_rd", rd_cnt - base, 2);

    // Continuous random stream, 400 frames.
    for (int i = 0; i < 810; i++) fifo_q.push_back(20'($urandom));
    refresh();
    step(400 * 128);
    check("stream_no_underrun", underrun, 1'b0);

    // Underrun on frame 5 left only.
    en = 1'b0;
    step(4);
    fifo_q.delete();
    for (int i = 0; i < 40; i++) fifo_q.push_back(20'($urandom));
    refresh();
    en = 1'b1;
    step(641);
    force_empty = 1'b1;
    refresh();
    step(1);
    force_empty = 1'b0;
    refresh();
    check("underrun_set", underrun, 1'b1);
    step(1200);
    check("underrun_sticky", underrun, 1'b1);

    // en dropped during cell 40, then re-enabled.
    en = 1'b0;
    step(3);
    en = 1'b1;
    step(42);
    en = 1'b0;
    base = rd_cnt;
    step(20);
    check("drop_no_rd", rd_cnt - base, 0);
    check("drop_dout", dout, 1'b0);
    for (int i = 0; i < 10; i++) fifo_q.push_back(20'($urandom));
    refresh();
    en = 1'b1;
    step(300);

    // Asynchronous reset during cell 90.
    en = 1'b0;
    step(3);
    en = 1'b1;
    step(92);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dout", dout, 1'b0);
    check("arst_rd_en", rd_en, 1'b0);
    check("arst_frame_start", frame_start, 1'b0);
    check("arst_underrun", underrun, 1'b0);
    step(3);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) fifo_q.push_back(20'($urandom));
    refresh();
    step(600);
    check("final_underrun", underrun, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
